// File: rtl/fp_pkg.sv
// fp_pkg: widths, FSM states and constants for the sequential FP subtractor.
package fp_pkg;
  localparam int EXP_W = 8;
  localparam int FRAC_W = 23;
  localparam int MANT_W = 28;
  localparam logic [31:0] QNAN = 32'h7FC00000;
  localparam logic [7:0] EXP_MAX = 8'hFF;
  typedef enum logic [2:0] {IDLE, ALIGN, SUB, NORM, ROUND, DONE} state_e;
endpackage

// File: rtl/fp_sub_seq_if.sv
// fp_sub_seq_if: operand/result valid-ready handshake of the FP subtractor.
interface fp_sub_seq_if;
  logic in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, s;
  modport master(output in_valid, a, b, out_ready, input in_ready, out_valid, s);
  modport slave(input in_valid, a, b, out_ready, output in_ready, out_valid, s);
endinterface

// File: rtl/fp_rne_round.sv
// fp_rne_round: round-to-nearest-even of a normalised 28-bit working mantissa into packed exponent/fraction.
module fp_rne_round
  import fp_pkg::*;
(
  input  logic [MANT_W-1:0] mant_i,
  input  logic [9:0]        exp_i,
  output logic [EXP_W-1:0]  exp_o,
  output logic [FRAC_W-1:0] frac_o,
  output logic              ovf_o
);
  logic inc;
  logic [24:0] m;
  logic [9:0] e;
  always_comb begin
    inc = mant_i[2] && (mant_i[1] || mant_i[0] || mant_i[3]);
    m = mant_i[27:3] + {24'b0, inc};
    // m[23] clear means the value stayed denormal, so the packed exponent is 0
    e = m[24] ? exp_i + 10'd1 : (m[23] ? exp_i : 10'd0);
    exp_o = e[7:0];
    frac_o = m[22:0];
    ovf_o = e >= {2'b0, EXP_MAX};
  end
endmodule

// File: rtl/fp_sub_seq.sv
// fp_sub_seq: multi-cycle IEEE-754 single subtractor s = a - b with bit-serial align/normalise.
// Define FP_SUB_SPECIAL_EN to handle NaN/infinity inputs; otherwise exponent 255 is treated as finite.
module fp_sub_seq
  import fp_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  fp_sub_seq_if.slave  io
);
  state_e state_q;
  logic sc_q, same_q;
  logic [MANT_W-1:0] mc_q, md_q;
  logic [9:0] exp_q;
  logic [7:0] sh_q;
  logic [31:0] s_q;
  logic [31:0] bn;
  logic a_big;
  logic [7:0] ea, eb;
  logic [MANT_W-1:0] ma, mb, sum;
  logic [EXP_W-1:0] r_exp;
  logic [FRAC_W-1:0] r_frac;
  logic r_ovf;
  always_comb begin
    bn = {~io.b[31], io.b[30:0]};
    a_big = io.a[30:0] >= io.b[30:0];
    ea = io.a[30:23] == 8'd0 ? 8'd1 : io.a[30:23];
    eb = io.b[30:23] == 8'd0 ? 8'd1 : io.b[30:23];
    ma = {1'b0, |io.a[30:23], io.a[22:0], 3'b0};
    mb = {1'b0, |io.b[30:23], io.b[22:0], 3'b0};
    sum = same_q ? mc_q + md_q : mc_q - md_q;
  end
`ifdef FP_SUB_SPECIAL_EN
  logic a_inf, b_inf, a_nan, b_nan, sp;
  logic [31:0] sp_val;
  always_comb begin
    a_inf = io.a[30:23] == EXP_MAX && io.a[22:0] == 23'd0;
    b_inf = io.b[30:23] == EXP_MAX && io.b[22:0] == 23'd0;
    a_nan = io.a[30:23] == EXP_MAX && io.a[22:0] != 23'd0;
    b_nan = io.b[30:23] == EXP_MAX && io.b[22:0] != 23'd0;
    sp = a_inf || b_inf || a_nan || b_nan;
    sp_val = (a_nan || b_nan || (a_inf && b_inf && io.a[31] != bn[31])) ? QNAN
           : {a_inf ? io.a[31] : bn[31], EXP_MAX, 23'b0};
  end
`endif
  fp_rne_round u_round (.mant_i(mc_q), .exp_i(exp_q), .exp_o(r_exp), .frac_o(r_frac), .ovf_o(r_ovf));
  assign io.in_ready = state_q == IDLE;
  assign io.out_valid = state_q == DONE;
  assign io.s = s_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sc_q <= 1'b0;
      same_q <= 1'b0;
      mc_q <= '0;
      md_q <= '0;
      exp_q <= '0;
      sh_q <= '0;
      s_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (io.in_valid) begin
          sc_q <= a_big ? io.a[31] : bn[31];
          same_q <= io.a[31] == bn[31];
          mc_q <= a_big ? ma : mb;
          md_q <= a_big ? mb : ma;
          exp_q <= {2'b0, a_big ? ea : eb};
          sh_q <= a_big ? ea - eb : eb - ea;
          state_q <= ALIGN;
`ifdef FP_SUB_SPECIAL_EN
          if (sp) begin
            s_q <= sp_val;
            state_q <= DONE;
          end
`endif
        end
        ALIGN: begin
          md_q <= sh_q > 8'd26 ? {27'b0, |md_q}
                : sh_q != 8'd0 ? {1'b0, md_q[27:2], md_q[1] | md_q[0]} : md_q;
          sh_q <= (sh_q > 8'd26 || sh_q == 8'd0) ? 8'd0 : sh_q - 8'd1;
          state_q <= (sh_q > 8'd26 || sh_q <= 8'd1) ? SUB : ALIGN;
        end
        SUB: begin
          mc_q <= sum;
          s_q <= 32'h0;
          state_q <= sum == '0 ? DONE : NORM;
        end
        NORM: begin
          if (mc_q[27]) begin
            mc_q <= {1'b0, mc_q[27:2], mc_q[1] | mc_q[0]};
            exp_q <= exp_q + 10'd1;
            state_q <= ROUND;
          end else if (!mc_q[26] && exp_q > 10'd1) begin
            mc_q <= mc_q << 1;
            exp_q <= exp_q - 10'd1;
            // look ahead so the cycle that completes the shift also leaves NORM
            state_q <= (mc_q[25] || exp_q == 10'd2) ? ROUND : NORM;
          end else state_q <= ROUND;
        end
        ROUND: begin
          s_q <= r_ovf ? {sc_q, EXP_MAX, 23'b0} : {sc_q, r_exp, r_frac};
          state_q <= DONE;
        end
        DONE: if (io.out_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_sub_seq.sv
// tb_fp_sub_seq: directed vectors with a scoreboard queue checked by an independent output monitor.
module tb_fp_sub_seq;
  import fp_pkg::*;
  typedef struct {
    logic [31:0] s;
    int lat;
  } exp_t;
  logic clk = 0;
  logic rst = 1;
  int total = 0, bad = 0;
  int cyc = 0, t_acc = 0;
  bit seen = 0;
  logic [31:0] held;
  exp_t sb[$];
  fp_sub_seq_if io();
  fp_sub_seq dut (.clk(clk), .rst(rst), .io(io.slave));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (io.in_valid && io.in_ready) t_acc <= cyc + 1;
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask
  always @(negedge clk) begin
    if (io.out_valid && !rst) begin
      if (!seen) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_output: got %h required none", io.s);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("result", io.s, e.s);
          chk("latency", 32'(cyc - t_acc), 32'(e.lat));
        end
        held = io.s;
        seen = 1;
      end else chk("hold_s", io.s, held);
      chk("in_ready_busy", {31'b0, io.in_ready}, 32'd0);
      if (io.out_ready) seen = 0;
    end
  end
  task automatic send(input logic [31:0] av, input logic [31:0] bv, input logic [31:0] ev, input int lat, input bit push);
    bit ok = 0;
    if (push) sb.push_back('{ev, lat});
    io.a = av;
    io.b = bv;
    io.in_valid = 1;
    for (int n = 0; n < 100 && !ok; n++) begin
      ok = io.in_ready;
      @(posedge clk);
      #1;
    end
    io.in_valid = 0;
    io.a = 32'hDEADBEEF;
    io.b = 32'h12345678;
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got in_ready=0 required 1");
    end
  endtask
  task automatic wait_done();
    bit ok = 0;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      ok = sb.size() == 0 && !seen;
    end
    @(posedge clk);
    #1;
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got pending=%0d required 0", sb.size());
    end
  endtask
  task automatic op(input logic [31:0] av, input logic [31:0] bv, input logic [31:0] ev, input int lat);
    send(av, bv, ev, lat, 1);
    wait_done();
  endtask
  initial begin
    io.in_valid = 0;
    io.out_ready = 1;
    io.a = 0;
    io.b = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("reset_in_ready", {31'b0, io.in_ready}, 32'd1);
    chk("reset_out_valid", {31'b0, io.out_valid}, 32'd0);
    chk("reset_s", io.s, 32'h0);
    op(32'h40400000, 32'h3F800000, 32'h40000000, 4);
    op(32'h3F800000, 32'h3F800000, 32'h00000000, 2);
    op(32'h3F800000, 32'hBF800000, 32'h40000000, 4);
    op(32'h3F800000, 32'h30800000, 32'h3F800000, 4);
    op(32'h00000003, 32'h00000001, 32'h00000002, 4);
    op(32'h00800000, 32'h00000001, 32'h007FFFFF, 4);
    op(32'h3F800000, 32'h3F400000, 32'h3E800000, 5);
    op(32'h3F800000, 32'h35800000, 32'h3F7FFFF0, 23);
    op(32'h3F800000, 32'h33000000, 32'h3F800000, 28);
    op(32'h3F800000, 32'h40400000, 32'hC0000000, 4);
    op(32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F800000, 4);
    io.out_ready = 0;
    send(32'h40400000, 32'h3F800000, 32'h40000000, 4, 1);
    for (int n = 0; n < 20 && !io.out_valid; n++) begin
      @(posedge clk);
      #1;
    end
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    chk("bp_out_valid", {31'b0, io.out_valid}, 32'd1);
    io.out_ready = 1;
    wait_done();
    send(32'h3F800000, 32'h35800000, 32'h0, 0, 0);
    repeat (4) @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    #1 rst = 0;
    chk("rst_out_valid", {31'b0, io.out_valid}, 32'd0);
    chk("rst_in_ready", {31'b0, io.in_ready}, 32'd1);
    chk("rst_s", io.s, 32'h0);
    op(32'h40400000, 32'h3F800000, 32'h40000000, 4);
`ifdef FP_SUB_SPECIAL_EN
    op(32'h7F800000, 32'h7F800000, 32'h7FC00000, 1);
    op(32'h7F800000, 32'h3F800000, 32'h7F800000, 1);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fp_sub_seq.md
# fp_sub_seq

Multi-cycle IEEE-754 single-precision subtractor computing `s = a - b`, the inverse-direction companion to the combinational `fp_adder` in the FP datapath. It uses a valid/ready handshake on both sides and processes one operation at a time. Alignment and normalisation shift one bit per cycle, so a small, narrow datapath replaces the wide barrel shifters. Rounding is round-to-nearest-even, and denormal handling matches `fp_adder`.

## Interface
- No parameters. Widths are fixed at 32/8/23.
- clk  in  1  Single clock, all state updates on the rising edge.
- rst  in  1  Synchronous, active-high reset.
- in_valid  in  1  Operand pair `a`/`b` is valid.
- in_ready  out  1  High only in IDLE.
- a  in  32  Minuend.
- b  in  32  Subtrahend.
- out_valid  out  1  Result `s` is valid.
- out_ready  in  1  Consumer accepts `s`.
- s  out  32  Result `a - b`, registered.

## Operation
- **Working mantissa (28 bits):**
  - [27] carry
  - [26] hidden bit
  - [25:3] fraction
  - [2] guard
  - [1] round
  - [0] sticky
- **Unpack rules:**
  - Exponent 0 gives effective exponent 1 and hidden bit 0.
  - Any other exponent gives hidden bit 1.
- **IDLE:** on `in_valid && in_ready`:
  - Register `a` and `b` with b's sign inverted.
  - Order the operands so C has the larger {exp,frac} magnitude; ties leave `a` as C.
  - `shift = effC - effD`.
  - Go to ALIGN.
- **ALIGN:**
  - `shift == 0`: one cycle, no change.
  - `shift > 26`: one cycle; D becomes {27'b0, |D}.
  - Otherwise: each cycle D shifts right 1, the shifted-out bit ORs into sticky, and `shift` decrements. Exit when `shift == 0`.
- **SUB (one cycle):**
  - Equal signs: R = C + D.
  - Different signs: R = C - D, which is never negative.
  - Result sign = sign of C.
  - If R == 0: result is +0 (0x00000000); go to DONE.
- **NORM:**
  - If R[27]: shift right 1 with sticky and exp+1, in one cycle.
  - Otherwise, while R[26]==0 and exp>1: shift left 1 and exp-1, one bit per cycle.
  - A NORM visit with no shift still takes one cycle.
  - Ending with exp==1 and R[26]==0 gives a denormal (packed exponent 0).
- **ROUND (one cycle):**
  - Round to nearest even: increment when G && (R|S|LSB).
  - Mantissa carry-out: exp+1 and fraction 0.
  - A denormal rounding into R[26]: packed exponent becomes 1.
  - Packed exponent ≥255: infinity, i.e. {sign, 8'hFF, 23'b0}.
- **DONE:** `out_valid=1` and `s` held stable until `out_ready`; then IDLE.

## Timing
- Reset values:
  - state = IDLE
  - `in_ready = 1`
  - `out_valid = 0`
  - `s = 32'h0`
  - all internal registers = 0
- Latency from the acceptance edge to the first cycle with `out_valid` high = La + 1 + Ln + 1.
  - La: ALIGN cycles, 1..26.
  - Ln: NORM cycles, 1..26.
  - The zero-result path takes La + 1.
- Minimum latency is 2 cycles (zero result); maximum is 54.
- `in_ready` is low from the cycle after acceptance until the cycle after the DONE handshake. There is no overlap of operations.
- `out_valid` and `out_ready` both high transfers the result; the next cycle is IDLE, so `in_ready = 1`.
- Reset asserted in any state takes effect at the next edge and discards the operation in flight.
- `a`/`b` change while `in_ready` is low: ignored.

## Configuration
- `FP_SUB_SPECIAL_EN` defined:
  - Any NaN input gives 0x7FC00000.
  - Inf - Inf with the same sign gives 0x7FC00000.
  - Any other infinity input gives a correctly signed infinity.
  - All of these bypass ALIGN/NORM and go to DONE 1 cycle after acceptance.
- `FP_SUB_SPECIAL_EN` undefined:
  - Exponent 255 is treated as a finite exponent, as `fp_adder` does.
  - Results for such inputs are deterministic but unspecified.

## Structure
- Package `fp_pkg` holds:
  - The exponent, fraction and working widths.
  - The state enum (IDLE, ALIGN, SUB, NORM, ROUND, DONE).
  - The constants QNAN=32'h7FC00000 and EXP_MAX=8'hFF.
- Sub-module `fp_rne_round`: combinational RNE of the 28-bit mantissa plus exponent, giving packed exponent/fraction and overflow.

## Test plan
- a=0x40400000 (3.0), b=0x3F800000 -> s=0x40000000, with out_valid exactly 4 cycles after acceptance.
- a=0x3F800000, b=0x3F800000 -> s=0x00000000, latency 2. Also a=0x3F800000, b=0xBF800000 -> s=0x40000000 (carry path).
- a=0x3F800000, b=0x30800000 (2^-30) -> shortcut ALIGN then RNE, s=0x3F800000.
- Denormals: a=0x00000003, b=0x00000001 -> s=0x00000002. Also a=0x00800000, b=0x00000001 -> s=0x007FFFFF.
- Backpressure and reset:
  - Hold out_ready=0 for 5 cycles -> s/out_valid stable and in_ready=0.
  - Assert rst in ALIGN of a long-shift operation -> next cycle out_valid=0, in_ready=1, s=0.
- With `FP_SUB_SPECIAL_EN`:
  - a=0x7F800000, b=0x7F800000 -> 0x7FC00000.
  - a=0x7F800000, b=0x3F800000 -> 0x7F800000.
